// File: rtl/prism_sp_rx_dma_write_mc.sv
// Multi-queue receive DMA write sequencer: pairs cookie/metadata heads per queue,
// arbitrates round-robin, drives one DMA engine and pushes completion cookies.
module prism_sp_rx_dma_write_mc #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 14,
  parameter int META_W = 24,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          ck_empty,
  output logic [NUM_CH-1:0]          ck_rd_en,
  input  logic [NUM_CH*ADDR_W-1:0]   ck_addr,
  input  logic [NUM_CH*LEN_W-1:0]    ck_buf_size,
  input  logic [NUM_CH-1:0]          md_empty,
  output logic [NUM_CH-1:0]          md_rd_en,
  input  logic [NUM_CH*LEN_W-1:0]    md_size,
  input  logic [NUM_CH*META_W-1:0]   md_meta,
  output logic [ADDR_W-1:0]          dma_addr,
  output logic [LEN_W-1:0]           dma_len,
  output logic                       dma_start,
  input  logic                       dma_busy,
  input  logic                       oc_full,
  output logic                       oc_wr_en,
  output logic [CH_W-1:0]            oc_ch,
  output logic [ADDR_W-1:0]          oc_addr,
  output logic [LEN_W-1:0]           oc_size,
  output logic                       oc_trunc,
  output logic [META_W-1:0]          oc_meta,
  output logic [31:0]                trunc_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREBUSY  = 2'd1,
    ST_BUSY     = 2'd2,
    ST_WAIT_OUT = 2'd3
  } state_t;

  logic [ADDR_W-1:0] ck_addr_a [NUM_CH];
  logic [LEN_W-1:0]  ck_buf_a  [NUM_CH];
  logic [LEN_W-1:0]  md_size_a [NUM_CH];
  logic [META_W-1:0] md_meta_a [NUM_CH];
  logic [NUM_CH-1:0] eligible;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
    assign ck_addr_a[gi] = ck_addr[gi*ADDR_W +: ADDR_W];
    assign ck_buf_a[gi]  = ck_buf_size[gi*LEN_W +: LEN_W];
    assign md_size_a[gi] = md_size[gi*LEN_W +: LEN_W];
    assign md_meta_a[gi] = md_meta[gi*META_W +: META_W];
    assign eligible[gi]  = ~ck_empty[gi] & ~md_empty[gi];
  end

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]   ck_rd_en_q, ck_rd_en_d;
  logic [NUM_CH-1:0]   md_rd_en_q, md_rd_en_d;
  logic                dma_start_q, dma_start_d;
  logic [ADDR_W-1:0]   dma_addr_q, dma_addr_d;
  logic [LEN_W-1:0]    dma_len_q, dma_len_d;
  logic                oc_wr_en_q, oc_wr_en_d;
  logic [CH_W-1:0]     oc_ch_q, oc_ch_d;
  logic [ADDR_W-1:0]   oc_addr_q, oc_addr_d;
  logic [LEN_W-1:0]    oc_size_q, oc_size_d;
  logic                oc_trunc_q, oc_trunc_d;
  logic [META_W-1:0]   oc_meta_q, oc_meta_d;
  logic [31:0]         trunc_cnt_q, trunc_cnt_d;

  // Two-pass search: first eligible queue at/above the pointer, else lowest eligible (wrap).
  logic            hi_vld, lo_vld, grant_vld;
  logic [CH_W-1:0] hi_ch, lo_ch, grant_ch;
  logic [NUM_CH-1:0] grant_oh;

  always_comb begin
    hi_vld = 1'b0;
    hi_ch  = '0;
    lo_vld = 1'b0;
    lo_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (eligible[i] && !lo_vld) begin
        lo_vld = 1'b1;
        lo_ch  = CH_W'(i);
      end
      if (eligible[i] && !hi_vld && (CH_W'(i) >= rr_ptr_q)) begin
        hi_vld = 1'b1;
        hi_ch  = CH_W'(i);
      end
    end
    grant_vld = lo_vld;
    grant_ch  = hi_vld ? hi_ch : lo_ch;
    grant_oh  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_oh[i] = grant_vld && (CH_W'(i) == grant_ch);
    end
  end

  logic [LEN_W-1:0] sel_size, sel_buf, sel_len;
  logic             sel_trunc;

  assign sel_size  = md_size_a[grant_ch];
  assign sel_buf   = ck_buf_a[grant_ch];
  assign sel_trunc = sel_size > sel_buf;
  assign sel_len   = sel_trunc ? sel_buf : sel_size;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    ck_rd_en_d  = '0;
    md_rd_en_d  = '0;
    dma_start_d = 1'b0;
    dma_addr_d  = dma_addr_q;
    dma_len_d   = dma_len_q;
    oc_wr_en_d  = 1'b0;
    oc_ch_d     = oc_ch_q;
    oc_addr_d   = oc_addr_q;
    oc_size_d   = oc_size_q;
    oc_trunc_d  = oc_trunc_q;
    oc_meta_d   = oc_meta_q;
    trunc_cnt_d = trunc_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          ck_rd_en_d = grant_oh;
          md_rd_en_d = grant_oh;
          rr_ptr_d   = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
          oc_ch_d    = grant_ch;
          oc_addr_d  = ck_addr_a[grant_ch];
          oc_size_d  = sel_len;
          oc_trunc_d = sel_trunc;
          oc_meta_d  = md_meta_a[grant_ch];
          if (sel_trunc && (trunc_cnt_q != 32'hFFFF_FFFF)) begin
            trunc_cnt_d = trunc_cnt_q + 32'd1;
          end
          if (sel_len != '0) begin
            dma_start_d = 1'b1;
            dma_addr_d  = ck_addr_a[grant_ch];
            dma_len_d   = sel_len;
            state_d     = ST_PREBUSY;
          end else begin
            // Empty frame: nothing to move, go straight to the cookie push.
            state_d = ST_WAIT_OUT;
          end
        end
      end
      ST_PREBUSY: state_d = ST_BUSY;
      ST_BUSY: begin
        if (!dma_busy) begin
          if (!oc_full) begin
            oc_wr_en_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT_OUT;
          end
        end
      end
      ST_WAIT_OUT: begin
        if (!oc_full) begin
          oc_wr_en_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      ck_rd_en_q  <= '0;
      md_rd_en_q  <= '0;
      dma_start_q <= 1'b0;
      dma_addr_q  <= '0;
      dma_len_q   <= '0;
      oc_wr_en_q  <= 1'b0;
      oc_ch_q     <= '0;
      oc_addr_q   <= '0;
      oc_size_q   <= '0;
      oc_trunc_q  <= 1'b0;
      oc_meta_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      ck_rd_en_q  <= ck_rd_en_d;
      md_rd_en_q  <= md_rd_en_d;
      dma_start_q <= dma_start_d;
      dma_addr_q  <= dma_addr_d;
      dma_len_q   <= dma_len_d;
      oc_wr_en_q  <= oc_wr_en_d;
      oc_ch_q     <= oc_ch_d;
      oc_addr_q   <= oc_addr_d;
      oc_size_q   <= oc_size_d;
      oc_trunc_q  <= oc_trunc_d;
      oc_meta_q   <= oc_meta_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign ck_rd_en  = ck_rd_en_q;
  assign md_rd_en  = md_rd_en_q;
  assign dma_start = dma_start_q;
  assign dma_addr  = dma_addr_q;
  assign dma_len   = dma_len_q;
  assign oc_wr_en  = oc_wr_en_q;
  assign oc_ch     = oc_ch_q;
  assign oc_addr   = oc_addr_q;
  assign oc_size   = oc_size_q;
  assign oc_trunc  = oc_trunc_q;
  assign oc_meta   = oc_meta_q;
  assign trunc_cnt = trunc_cnt_q;

endmodule

// File: tb/tb_prism_sp_rx_dma_write_mc.sv
// Bench for prism_sp_rx_dma_write_mc: FWFT FIFO and DMA models around the DUT,
// directed scenarios plus randomized multi-queue traffic against a frame-level model.
module tb_prism_sp_rx_dma_write_mc;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 14;
  localparam int META_W = 24;
  localparam int CH_W   = 2;

  logic                      clock = 1'b0;
  logic                      resetn = 1'b0;
  logic [NUM_CH-1:0]         ck_empty, ck_rd_en, md_empty, md_rd_en;
  logic [NUM_CH*ADDR_W-1:0]  ck_addr;
  logic [NUM_CH*LEN_W-1:0]   ck_buf_size, md_size;
  logic [NUM_CH*META_W-1:0]  md_meta;
  logic [ADDR_W-1:0]         dma_addr, oc_addr;
  logic [LEN_W-1:0]          dma_len, oc_size;
  logic                      dma_start, dma_busy, oc_full, oc_wr_en, oc_trunc;
  logic [CH_W-1:0]           oc_ch;
  logic [META_W-1:0]         oc_meta;
  logic [31:0]               trunc_cnt;

  int n_vec = 0;
  int n_err = 0;
  int dma_lat = 2;
  logic [31:0] exp_trunc = 0;

  always #5 clock = ~clock;

  prism_sp_rx_dma_write_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .META_W(META_W), .CH_W(CH_W)
  ) dut (
    .clock(clock), .resetn(resetn),
    .ck_empty(ck_empty), .ck_rd_en(ck_rd_en), .ck_addr(ck_addr), .ck_buf_size(ck_buf_size),
    .md_empty(md_empty), .md_rd_en(md_rd_en), .md_size(md_size), .md_meta(md_meta),
    .dma_addr(dma_addr), .dma_len(dma_len), .dma_start(dma_start), .dma_busy(dma_busy),
    .oc_full(oc_full), .oc_wr_en(oc_wr_en), .oc_ch(oc_ch), .oc_addr(oc_addr),
    .oc_size(oc_size), .oc_trunc(oc_trunc), .oc_meta(oc_meta), .trunc_cnt(trunc_cnt)
  );

  // FWFT FIFO models: write pointers owned by the stimulus, read pointers by the pop process.
  logic [ADDR_W-1:0] ck_addr_mem [NUM_CH][256];
  logic [LEN_W-1:0]  ck_buf_mem  [NUM_CH][256];
  logic [LEN_W-1:0]  md_size_mem [NUM_CH][256];
  logic [META_W-1:0] md_meta_mem [NUM_CH][256];
  logic [7:0] ck_wr [NUM_CH] = '{default: 8'd0};
  logic [7:0] md_wr [NUM_CH] = '{default: 8'd0};
  logic [7:0] ck_rd [NUM_CH] = '{default: 8'd0};
  logic [7:0] md_rd [NUM_CH] = '{default: 8'd0};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
    assign ck_empty[gi] = (ck_wr[gi] == ck_rd[gi]);
    assign md_empty[gi] = (md_wr[gi] == md_rd[gi]);
    assign ck_addr[gi*ADDR_W +: ADDR_W]     = ck_addr_mem[gi][ck_rd[gi]];
    assign ck_buf_size[gi*LEN_W +: LEN_W]   = ck_buf_mem[gi][ck_rd[gi]];
    assign md_size[gi*LEN_W +: LEN_W]       = md_size_mem[gi][md_rd[gi]];
    assign md_meta[gi*META_W +: META_W]     = md_meta_mem[gi][md_rd[gi]];
  end

  always @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (ck_rd_en[i]) ck_rd[i] <= ck_rd[i] + 8'd1;
      if (md_rd_en[i]) md_rd[i] <= md_rd[i] + 8'd1;
    end
  end

  // DMA engine: busy for dma_lat cycles starting the cycle after dma_start.
  int dma_cnt = 0;
  always @(posedge clock) begin
    if (!resetn) begin
      dma_busy <= 1'b0;
      dma_cnt  <= 0;
    end else if (dma_start) begin
      dma_busy <= 1'b1;
      dma_cnt  <= dma_lat;
    end else if (dma_busy) begin
      dma_cnt <= dma_cnt - 1;
      if (dma_cnt <= 1) dma_busy <= 1'b0;
    end
  end

  task automatic push_ck(input int ch, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] b);
    ck_addr_mem[ch][ck_wr[ch]] = a;
    ck_buf_mem[ch][ck_wr[ch]]  = b;
    ck_wr[ch] = ck_wr[ch] + 8'd1;
  endtask

  task automatic push_md(input int ch, input logic [LEN_W-1:0] s, input logic [META_W-1:0] m);
    md_size_mem[ch][md_wr[ch]] = s;
    md_meta_mem[ch][md_wr[ch]] = m;
    md_wr[ch] = md_wr[ch] + 8'd1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    exp_trunc = 0;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (dma_start) seen = 1'b1;
    end
  endtask

  task automatic wait_push(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (oc_wr_en) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({ck_rd_en, md_rd_en, dma_start, oc_wr_en} !== '0) begin
      n_err++;
      $display("FAIL reset_pulses got %b exp 0", {ck_rd_en, md_rd_en, dma_start, oc_wr_en});
    end
    n_vec++;
    if ({dma_addr, dma_len, oc_ch, oc_addr, oc_size, oc_trunc, oc_meta} !== '0) begin
      n_err++;
      $display("FAIL reset_data got addr=%h len=%0d oc_addr=%h oc_size=%0d exp 0", dma_addr, dma_len, oc_addr, oc_size);
    end
    n_vec++;
    if (trunc_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_trunc_cnt got %0d exp 0", trunc_cnt);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single();
    bit seen;
    push_ck(2, 64'h1000, 14'd2048);
    push_md(2, 14'd64, 24'h00A5A5);
    wait_start(10, seen);
    n_vec++;
    if (!seen || dma_addr !== 64'h1000 || dma_len !== 14'd64) begin
      n_err++;
      $display("FAIL single_start got seen=%0b addr=%h len=%0d exp addr=1000 len=64", seen, dma_addr, dma_len);
    end
    n_vec++;
    if (ck_rd_en !== 4'b0100 || md_rd_en !== 4'b0100) begin
      n_err++;
      $display("FAIL single_pop got ck=%b md=%b exp 0100", ck_rd_en, md_rd_en);
    end
    wait_push(20, seen);
    n_vec++;
    if (!seen || oc_ch !== 2'd2 || oc_size !== 14'd64 || oc_trunc !== 1'b0 ||
        oc_addr !== 64'h1000 || oc_meta !== 24'h00A5A5) begin
      n_err++;
      $display("FAIL single_push got seen=%0b ch=%0d size=%0d trunc=%0b addr=%h meta=%h exp ch=2 size=64 trunc=0",
               seen, oc_ch, oc_size, oc_trunc, oc_addr, oc_meta);
    end
    $display("single: ch=2 addr=%h len=%0d", oc_addr, oc_size);
  endtask

  task automatic test_trunc();
    bit seen;
    push_ck(0, 64'hDEAD_0000, 14'd2048);
    push_md(0, 14'd3000, 24'h123456);
    wait_start(10, seen);
    n_vec++;
    if (!seen || dma_len !== 14'd2048) begin
      n_err++;
      $display("FAIL trunc_dma_len got seen=%0b len=%0d exp 2048", seen, dma_len);
    end
    wait_push(20, seen);
    exp_trunc = exp_trunc + 1;
    n_vec++;
    if (!seen || oc_size !== 14'd2048 || oc_trunc !== 1'b1 || trunc_cnt !== exp_trunc) begin
      n_err++;
      $display("FAIL trunc_push got size=%0d trunc=%0b cnt=%0d exp 2048 1 %0d", oc_size, oc_trunc, trunc_cnt, exp_trunc);
    end
    $display("trunc: size=3000 buf=2048 -> len=%0d cnt=%0d", oc_size, trunc_cnt);
  endtask

  task automatic test_zero_len();
    bit seen = 1'b0;
    bit extra = 1'b0;
    push_ck(1, 64'h2000, 14'd100);
    push_md(1, 14'd0, 24'h0000FF);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (ck_rd_en != '0) seen = 1'b1;
    end
    n_vec++;
    if (!seen || dma_start !== 1'b0 || ck_rd_en !== 4'b0010 || md_rd_en !== 4'b0010) begin
      n_err++;
      $display("FAIL zero_pop got seen=%0b start=%0b ck=%b md=%b exp start=0 pop=0010", seen, dma_start, ck_rd_en, md_rd_en);
    end
    @(negedge clock);
    n_vec++;
    if (oc_wr_en !== 1'b1 || oc_size !== 14'd0 || oc_ch !== 2'd1 || oc_trunc !== 1'b0) begin
      n_err++;
      $display("FAIL zero_push got wr=%0b size=%0d ch=%0d trunc=%0b exp 1 0 1 0", oc_wr_en, oc_size, oc_ch, oc_trunc);
    end
    repeat (4) begin
      @(negedge clock);
      if (dma_start || oc_wr_en) extra = 1'b1;
    end
    n_vec++;
    if (extra) begin
      n_err++;
      $display("FAIL zero_extra got extra activity=1 exp 0");
    end
    $display("zero: push two cycles after grant, size=%0d", oc_size);
  endtask

  task automatic test_late_meta();
    bit seen;
    bit early = 1'b0;
    push_ck(1, 64'h3000, 14'd512);
    repeat (10) begin
      @(negedge clock);
      if (ck_rd_en != '0 || md_rd_en != '0 || dma_start) early = 1'b1;
    end
    n_vec++;
    if (early) begin
      n_err++;
      $display("FAIL late_meta_early got activity=1 exp 0");
    end
    push_md(1, 14'd200, 24'h00BEEF);
    wait_start(10, seen);
    n_vec++;
    if (!seen || ck_rd_en !== 4'b0010 || md_rd_en !== 4'b0010 || dma_addr !== 64'h3000 || dma_len !== 14'd200) begin
      n_err++;
      $display("FAIL late_meta_start got seen=%0b ck=%b md=%b addr=%h len=%0d exp 0010 3000 200",
               seen, ck_rd_en, md_rd_en, dma_addr, dma_len);
    end
    wait_push(20, seen);
    n_vec++;
    if (!seen || oc_ch !== 2'd1) begin
      n_err++;
      $display("FAIL late_meta_push got seen=%0b ch=%0d exp 1", seen, oc_ch);
    end
    $display("late_meta: start after metadata arrival, ch=%0d", oc_ch);
  endtask

  task automatic test_oc_full();
    bit seen;
    bit early = 1'b0;
    int pushes = 0;
    oc_full = 1'b1;
    dma_lat = 3;
    push_ck(3, 64'h4000, 14'd1024);
    push_md(3, 14'd300, 24'h000333);
    wait_start(10, seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (dma_busy) seen = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (!dma_busy) seen = 1'b1;
      else @(negedge clock);
    end
    repeat (5) begin
      @(negedge clock);
      if (oc_wr_en) early = 1'b1;
    end
    n_vec++;
    if (!seen || early) begin
      n_err++;
      $display("FAIL oc_full_hold got done=%0b early_push=%0b exp 1 0", seen, early);
    end
    oc_full = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (oc_wr_en) begin
        pushes++;
        n_vec++;
        if (oc_ch !== 2'd3 || oc_size !== 14'd300) begin
          n_err++;
          $display("FAIL oc_full_data got ch=%0d size=%0d exp 3 300", oc_ch, oc_size);
        end
      end
    end
    n_vec++;
    if (pushes != 1) begin
      n_err++;
      $display("FAIL oc_full_count got %0d pushes exp 1", pushes);
    end
    $display("oc_full: %0d push after release", pushes);
  endtask

  task automatic test_reset_busy();
    bit seen;
    int pushes = 0;
    dma_lat = 8;
    push_ck(0, 64'h5000, 14'd100);
    push_md(0, 14'd150, 24'h000555);
    wait_start(10, seen);
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    exp_trunc = 0;
    n_vec++;
    if ({ck_rd_en, md_rd_en, dma_start, oc_wr_en, dma_addr, dma_len, oc_ch, oc_addr,
         oc_size, oc_trunc, oc_meta, trunc_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_busy_outputs got addr=%h size=%0d cnt=%0d wr=%0b exp 0", oc_addr, oc_size, trunc_cnt, oc_wr_en);
    end
    repeat (12) begin
      @(negedge clock);
      if (oc_wr_en || dma_start) pushes++;
    end
    n_vec++;
    if (!seen || pushes != 0) begin
      n_err++;
      $display("FAIL reset_busy_push got started=%0b activity=%0d exp 1 0", seen, pushes);
    end
    $display("reset_busy: frame abandoned");
  endtask

  typedef struct {
    int                ch;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              trunc;
    logic [META_W-1:0] meta;
  } frame_t;

  task automatic test_round_robin();
    frame_t exp_q[$];
    frame_t e;
    frame_t ent [NUM_CH][4];
    int cnt [NUM_CH];
    int taken [NUM_CH];
    int exp_ptr = 0;
    apply_reset();
    for (int round = 0; round < 6; round++) begin
      int total = 0;
      int starts = 0;
      int done = 0;
      int prev_t = 0;
      int t = 0;
      dma_lat = int'($urandom_range(1, 5));
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] = (round == 0) ? 2 : int'($urandom_range(0, 3));
        taken[c] = 0;
      end
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[round % NUM_CH] = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int j = 0; j < cnt[c]; j++) begin
          logic [LEN_W-1:0] b, s;
          b = LEN_W'($urandom_range(64, 4096));
          s = LEN_W'($urandom_range(1, 5000));
          ent[c][j].ch    = c;
          ent[c][j].addr  = {$urandom, $urandom};
          ent[c][j].trunc = s > b;
          ent[c][j].len   = (s > b) ? b : s;
          ent[c][j].meta  = META_W'($urandom);
          push_ck(c, ent[c][j].addr, b);
          push_md(c, s, ent[c][j].meta);
          total++;
        end
      end
      // Reference order: next loaded queue at or after the pointer, wrapping.
      for (int n = 0; n < total; n++) begin
        for (int o = 0; o < NUM_CH; o++) begin
          int c;
          c = (exp_ptr + o) % NUM_CH;
          if (taken[c] < cnt[c]) begin
            exp_q.push_back(ent[c][taken[c]]);
            taken[c]++;
            exp_ptr = (c + 1) % NUM_CH;
            break;
          end
        end
      end
      while (done < total && t < total * (dma_lat + 12) + 20) begin
        @(negedge clock);
        t++;
        if (dma_start) begin
          if (starts >= total) begin
            n_vec++;
            n_err++;
            $display("FAIL rr_extra_start got start %0d exp only %0d", starts, total);
          end else begin
            e = exp_q[starts];
            n_vec++;
            if (dma_addr !== e.addr || dma_len !== e.len || ck_rd_en !== (4'b1 << e.ch) || md_rd_en !== (4'b1 << e.ch)) begin
              n_err++;
              $display("FAIL rr_start[%0d] got addr=%h len=%0d ck=%b md=%b exp addr=%h len=%0d ch=%0d",
                       starts, dma_addr, dma_len, ck_rd_en, md_rd_en, e.addr, e.len, e.ch);
            end
            if (starts > 0) begin
              n_vec++;
              if (t - prev_t != 3 + dma_lat) begin
                n_err++;
                $display("FAIL rr_period got %0d cycles exp %0d", t - prev_t, 3 + dma_lat);
              end
            end
            prev_t = t;
            starts++;
          end
        end
        if (oc_wr_en) begin
          e = exp_q[done];
          if (e.trunc) exp_trunc = exp_trunc + 1;
          n_vec++;
          if (int'(oc_ch) != e.ch || oc_addr !== e.addr || oc_size !== e.len ||
              oc_trunc !== e.trunc || oc_meta !== e.meta || trunc_cnt !== exp_trunc) begin
            n_err++;
            $display("FAIL rr_push[%0d] got ch=%0d addr=%h size=%0d trunc=%0b meta=%h cnt=%0d exp ch=%0d addr=%h size=%0d trunc=%0b meta=%h cnt=%0d",
                     done, oc_ch, oc_addr, oc_size, oc_trunc, oc_meta, trunc_cnt,
                     e.ch, e.addr, e.len, e.trunc, e.meta, exp_trunc);
          end
          $display("rr round %0d frame %0d: ch=%0d len=%0d trunc=%0b", round, done, oc_ch, oc_size, oc_trunc);
          done++;
        end
      end
      n_vec++;
      if (done != total) begin
        n_err++;
        $display("FAIL rr_timeout got %0d completions exp %0d", done, total);
      end
      exp_q.delete();
      repeat (2) @(negedge clock);
    end
  endtask

  initial begin
    oc_full = 1'b0;
    test_reset();
    test_single();
    test_trunc();
    test_zero_len();
    test_late_meta();
    test_oc_full();
    test_reset_busy();
    test_round_robin();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
